guess_entry: RTL and testbench
==============================

Name: guess_entry

Overview:
- User-side end of the memorization round: collects the player's digit presses into a 16-bit BCD guess and compares it against the latched 16-bit target.
- Reports win/lose and counts attempts.
- Sits between the debounced keypad/switch front-end and the game controller/display.
- It is the consumer of the target value produced by the random-number path.

Parameters:
- NUM_DIGITS, 4, digits per guess; guess width = 4*NUM_DIGITS.
- MAX_ATTEMPTS, 3, wrong guesses allowed before lockout (1..15).
- DIGIT_MAX, 9, largest legal digit value.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- round_start  in  1  one-cycle pulse; latches target_in and starts a round.
- target_in  in  16  BCD target, digit 0 in [3:0], digit 3 in [15:12].
- digit_valid  in  1  one-cycle pulse per debounced key press.
- digit_in  in  4  digit value, sampled when digit_valid=1.
- clear  in  1  one-cycle pulse; discards the partial guess.
- user_int  out  16  guess being built (registered).
- digit_count  out  3  digits accepted in the current guess, 0..NUM_DIGITS.
- result_valid  out  1  one-cycle pulse when a guess has been judged.
- correct  out  1  judgement, valid with result_valid; held until the next judgement or round_start.
- digit_err  out  1  one-cycle pulse when a digit > DIGIT_MAX is rejected.
- attempts  out  4  wrong guesses this round.
- won  out  1  level; round won.
- locked  out  1  level; attempts exhausted.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE.
  - user_int=0, digit_count=0, result_valid=0, correct=0, digit_err=0, attempts=0, won=0, locked=0.
  - Internal target register cleared to 0.
  - Reset applied mid-entry or mid-check aborts everything immediately; no result pulse is produced.
- States: IDLE, ENTRY, CHECK, WON, LOCKED.
- round_start (any state): clock edge latches target_in.
  - Clears user_int, digit_count, attempts, correct, won and locked.
  - Goes to ENTRY.
  - Has priority over digit_valid, clear and any pending check on the same cycle.
- IDLE: all inputs except round_start are ignored.
- ENTRY, accepted digit: digit_valid=1 and digit_in<=DIGIT_MAX.
  - user_int <= {user_int[11:0], digit_in}; the first digit entered ends up in [15:12].
  - digit_count increments.
- ENTRY, rejected digit: digit_valid=1 and digit_in>DIGIT_MAX.
  - Digit is not stored; digit_err pulses the following cycle.
  - digit_count is unchanged.
- ENTRY, clear=1: user_int=0, digit_count=0.
  - clear wins over a simultaneous digit_valid.
  - clear does not change attempts.
- ENTRY to CHECK: when the accepted digit brings digit_count to NUM_DIGITS, the next state is CHECK.
- CHECK (exactly one cycle):
  - Compare user_int against the target register over the full 16 bits.
  - On the edge leaving CHECK, register correct and pulse result_valid for one cycle.
  - Latency: 4th digit edge N, CHECK during cycle N..N+1, result_valid high for cycle N+1..N+2.
  - digit_valid and clear are ignored while in CHECK.
- Equal guess: won=1, go to WON.
- Unequal guess, attempts+1 < MAX_ATTEMPTS:
  - attempts increments.
  - user_int and digit_count are cleared.
  - Return to ENTRY.
- Unequal guess, attempts+1 == MAX_ATTEMPTS: attempts increments, locked=1, go to LOCKED.
- WON and LOCKED:
  - Hold all outputs.
  - user_int keeps the judged guess for display.
  - Ignore digit_valid and clear; only round_start exits.
- attempts never exceeds MAX_ATTEMPTS; there is no wrap-around.
- digit_count never exceeds NUM_DIGITS.

Decomposition:
- Shared package game_pkg:
  - State enum constants ST_IDLE, ST_ENTRY, ST_CHECK, ST_WON, ST_LOCKED (3-bit).
  - DIGIT_MAX and NUM_DIGITS defaults.
  - BCD width constant DIGIT_W=4.
- One sub-module: digit_shift_reg.
  - Contains the NUM_DIGITS x 4-bit shift register with load, clear and count.
  - Also contains the range check that produces accept/reject.
- FSM, target register, comparator and attempt counter stay in guess_entry.

Test Plan:
- Reset then round_start with target=0x1234; enter 1,2,3,4 -> result_valid pulse one cycle after 4th digit, correct=1, won=1, user_int=0x1234, attempts=0.
- Target 0x5678; enter 5,6,7,9 -> correct=0, attempts=1, user_int=0, digit_count=0, back in ENTRY; re-enter 5,6,7,8 -> won=1.
- Three wrong guesses of 0x0000 on target 0x9999 -> attempts=3, locked=1; further digit presses leave user_int=0x0000 and produce no result_valid; round_start -> locked=0, attempts=0.
- Enter 3, digit 0xB, then 7 -> digit_err pulses once, digit_count=2, user_int=0x0037.
- Enter 1,2 then clear and digit_valid(4) on the same cycle -> user_int=0, digit_count=0 (clear wins).
- rst=0 asserted mid-way between clock edges after 3 digits -> all outputs 0 immediately, state IDLE; digit presses are ignored until round_start.

Source files
------------

// File: rtl/game_pkg.sv
// Shared constants, state encoding and digit helpers for the memorization game.
// Pure declarations, no timing or flow control.
package game_pkg;

  localparam int DIGIT_W        = 4;
  localparam int NUM_DIGITS_DEF = 4;
  localparam int DIGIT_MAX_DEF  = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ENTRY  = 3'd1,
    ST_CHECK  = 3'd2,
    ST_WON    = 3'd3,
    ST_LOCKED = 3'd4
  } state_t;

  function automatic logic digit_ok(input logic [DIGIT_W-1:0] d, input int dmax);
    return int'(d) <= dmax;
  endfunction

endpackage

// File: rtl/guess_entry_if.sv
// Keypad-side and result-side signals of guess_entry.
// master drives the key/round pulses; slave (guess_entry) returns guess state and verdict.
interface guess_entry_if
  import game_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF
);
  localparam int W  = DIGIT_W * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);

  logic               round_start;
  logic [W-1:0]       target_in;
  logic               digit_valid;
  logic [DIGIT_W-1:0] digit_in;
  logic               clear;
  logic [W-1:0]       user_int;
  logic [CW-1:0]      digit_count;
  logic               result_valid;
  logic               correct;
  logic               digit_err;
  logic [3:0]         attempts;
  logic               won;
  logic               locked;

  modport master (
    output round_start, target_in, digit_valid, digit_in, clear,
    input  user_int, digit_count, result_valid, correct, digit_err, attempts, won, locked
  );

  modport slave (
    input  round_start, target_in, digit_valid, digit_in, clear,
    output user_int, digit_count, result_valid, correct, digit_err, attempts, won, locked
  );

endinterface

// File: rtl/digit_shift_reg.sv
// BCD guess shift register with digit range check; accepted digits enter at the LSB.
// Updates on the key edge, accept/reject/full_next are combinational from the current inputs.
module digit_shift_reg
  import game_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int DIGIT_MAX  = DIGIT_MAX_DEF,
  localparam int W  = DIGIT_W * NUM_DIGITS,
  localparam int CW = $clog2(NUM_DIGITS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               key_vld,
  input  logic [DIGIT_W-1:0] key_dat,
  input  logic               clr,
  output logic [W-1:0]       value,
  output logic [CW-1:0]      count,
  output logic               accept,
  output logic               reject,
  output logic               full_next
);

  logic in_range;
  logic take;

  // A clear on the same cycle swallows the key press entirely, including its error.
  assign take      = en & key_vld & ~clr;
  assign in_range  = digit_ok(key_dat, DIGIT_MAX);
  assign accept    = take & in_range;
  assign reject    = take & ~in_range;
  assign full_next = accept & (count == CW'(NUM_DIGITS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
      count <= '0;
    end else if (clr) begin
      value <= '0;
      count <= '0;
    end else if (accept) begin
      value <= (value << DIGIT_W) | W'(key_dat);
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/guess_entry.sv
// Collects BCD digit presses into a guess, judges it one cycle after the last digit,
// and tracks wrong attempts up to a lockout; only round_start leaves WON/LOCKED.
module guess_entry
  import game_pkg::*;
#(
  parameter int NUM_DIGITS   = NUM_DIGITS_DEF,
  parameter int MAX_ATTEMPTS = 3,
  parameter int DIGIT_MAX    = DIGIT_MAX_DEF
) (
  input  logic         clk,
  input  logic         rst,
  guess_entry_if.slave bus
);

  localparam int W  = DIGIT_W * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);

  state_t        state, state_nxt;
  logic [W-1:0]  target;
  logic [W-1:0]  guess;
  logic [CW-1:0] count;
  logic [3:0]    attempts;
  logic          result_valid, correct, digit_err, won, locked;

  logic sr_en, sr_clr, sr_accept, sr_reject, sr_full_next;
  logic guess_eq, last_try, check_fail;

  assign guess_eq   = (guess == target);
  assign last_try   = (attempts + 4'd1) == 4'(MAX_ATTEMPTS);
  assign check_fail = (state == ST_CHECK) & ~guess_eq & ~last_try;
  assign sr_en      = (state == ST_ENTRY);
  // Retry wipes the guess on the same edge that reports the wrong verdict.
  assign sr_clr     = bus.round_start | (sr_en & bus.clear) | check_fail;

  digit_shift_reg #(
    .NUM_DIGITS (NUM_DIGITS),
    .DIGIT_MAX  (DIGIT_MAX)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .en        (sr_en),
    .key_vld   (bus.digit_valid),
    .key_dat   (bus.digit_in),
    .clr       (sr_clr),
    .value     (guess),
    .count     (count),
    .accept    (sr_accept),
    .reject    (sr_reject),
    .full_next (sr_full_next)
  );

  always_comb begin
    state_nxt = state;
    if (bus.round_start) begin
      state_nxt = ST_ENTRY;
    end else begin
      case (state)
        ST_ENTRY: if (sr_full_next) state_nxt = ST_CHECK;
        ST_CHECK: begin
          if (guess_eq)      state_nxt = ST_WON;
          else if (last_try) state_nxt = ST_LOCKED;
          else               state_nxt = ST_ENTRY;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      target       <= '0;
      attempts     <= '0;
      result_valid <= 1'b0;
      correct      <= 1'b0;
      digit_err    <= 1'b0;
      won          <= 1'b0;
      locked       <= 1'b0;
    end else begin
      state        <= state_nxt;
      digit_err    <= sr_reject;
      result_valid <= 1'b0;
      if (bus.round_start) begin
        target   <= bus.target_in;
        attempts <= '0;
        correct  <= 1'b0;
        won      <= 1'b0;
        locked   <= 1'b0;
      end else if (state == ST_CHECK) begin
        result_valid <= 1'b1;
        correct      <= guess_eq;
        if (guess_eq) begin
          won <= 1'b1;
        end else begin
          attempts <= attempts + 4'd1;
          if (last_try) locked <= 1'b1;
        end
      end
    end
  end

  assign bus.user_int     = guess;
  assign bus.digit_count  = count;
  assign bus.result_valid = result_valid;
  assign bus.correct      = correct;
  assign bus.digit_err    = digit_err;
  assign bus.attempts     = attempts;
  assign bus.won          = won;
  assign bus.locked       = locked;

endmodule

// File: tb/tb_guess_entry.sv
// Directed test-plan scenarios followed by random key traffic, all checked against a
// queue-based model of the guessing rules.
module tb_guess_entry;
  import game_pkg::*;

  localparam int ND   = 4;
  localparam int MAXA = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  guess_entry_if #(.NUM_DIGITS(ND)) bus ();

  guess_entry #(
    .NUM_DIGITS   (ND),
    .MAX_ATTEMPTS (MAXA),
    .DIGIT_MAX    (9)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a round is "open" while digits are collected; a full guess is judged next cycle.
  int          m_q[$];
  logic [15:0] m_tgt;
  int          m_att;
  bit          m_corr, m_won, m_lock, m_open, m_judge, m_rv, m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_guess();
    logic [15:0] v = '0;
    foreach (m_q[i]) v = (v << 4) | 16'(m_q[i]);
    return v;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_tgt = '0; m_att = 0;
    m_corr = 0; m_won = 0; m_lock = 0; m_open = 0; m_judge = 0; m_rv = 0; m_err = 0;
  endtask

  task automatic m_step(input bit rs, input logic [15:0] tin, input bit dv, input logic [3:0] d, input bit cl);
    m_rv = 0; m_err = 0;
    if (rs) begin
      m_tgt = tin; m_q.delete(); m_att = 0;
      m_corr = 0; m_won = 0; m_lock = 0; m_open = 1; m_judge = 0;
    end else if (m_judge) begin
      m_judge = 0; m_rv = 1;
      if (m_guess() == m_tgt) begin
        m_corr = 1; m_won = 1; m_open = 0;
      end else begin
        m_corr = 0; m_att++;
        if (m_att == MAXA) begin m_lock = 1; m_open = 0; end
        else m_q.delete();
      end
    end else if (m_open) begin
      if (cl) m_q.delete();
      else if (dv) begin
        if (d > 9) m_err = 1;
        else begin
          m_q.push_back(int'(d));
          if (m_q.size() == ND) m_judge = 1;
        end
      end
    end
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".user_int"},     32'(bus.user_int),     32'(m_guess()));
    chk({ctx, ".digit_count"},  32'(bus.digit_count),  32'(m_q.size()));
    chk({ctx, ".result_valid"}, 32'(bus.result_valid), 32'(m_rv));
    chk({ctx, ".correct"},      32'(bus.correct),      32'(m_corr));
    chk({ctx, ".digit_err"},    32'(bus.digit_err),    32'(m_err));
    chk({ctx, ".attempts"},     32'(bus.attempts),     32'(m_att));
    chk({ctx, ".won"},          32'(bus.won),          32'(m_won));
    chk({ctx, ".locked"},       32'(bus.locked),       32'(m_lock));
  endtask

  task automatic cycle(input string ctx, input bit rs, input logic [15:0] tin,
                       input bit dv, input logic [3:0] d, input bit cl);
    bus.round_start = rs; bus.target_in = tin;
    bus.digit_valid = dv; bus.digit_in = d; bus.clear = cl;
    @(posedge clk);
    m_step(rs, tin, dv, d, cl);
    #1;
    bus.round_start = 1'b0; bus.digit_valid = 1'b0; bus.clear = 1'b0;
    check_outputs(ctx);
  endtask

  task automatic press(input string ctx, input logic [3:0] d);
    cycle(ctx, 0, 16'h0, 1, d, 0);
  endtask

  task automatic idle(input string ctx);
    cycle(ctx, 0, 16'h0, 0, 4'h0, 0);
  endtask

  task automatic start(input string ctx, input logic [15:0] t);
    cycle(ctx, 1, t, 0, 4'h0, 0);
  endtask

  initial begin
    logic [15:0] t;
    bus.round_start = 0; bus.target_in = '0; bus.digit_valid = 0; bus.digit_in = '0; bus.clear = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 check_outputs("reset");
    #3 rst = 1'b1;

    // Correct first guess.
    start("t1", 16'h1234);
    press("t1", 1); press("t1", 2); press("t1", 3); press("t1", 4);
    idle("t1_judge");
    chk("t1_won_direct", 32'(bus.won), 32'd1);
    idle("t1_after");

    // One wrong guess then the right one.
    start("t2", 16'h5678);
    press("t2", 5); press("t2", 6); press("t2", 7); press("t2", 9);
    idle("t2_judge");
    chk("t2_attempts_direct", 32'(bus.attempts), 32'd1);
    press("t2", 5); press("t2", 6); press("t2", 7); press("t2", 8);
    idle("t2_judge2");

    // Lockout after three wrong guesses, then presses are ignored.
    start("t3", 16'h9999);
    for (int g = 0; g < MAXA; g++) begin
      for (int k = 0; k < ND; k++) press("t3", 0);
      idle("t3_judge");
    end
    chk("t3_locked_direct", 32'(bus.locked), 32'd1);
    press("t3_held", 5); press("t3_held", 1); idle("t3_held");
    start("t3_restart", 16'h9999);

    // Out-of-range digit rejected mid-entry.
    start("t4", 16'h0000);
    press("t4", 3); press("t4", 4'hB); press("t4", 7);
    chk("t4_user_direct", 32'(bus.user_int), 32'h0037);

    // Clear beats a simultaneous digit.
    start("t5", 16'h1111);
    press("t5", 1); press("t5", 2);
    cycle("t5_clr", 0, 16'h0, 1, 4'd4, 1);

    // Asynchronous reset between edges after three digits.
    start("t6", 16'h4321);
    press("t6", 4); press("t6", 3); press("t6", 2);
    #2 rst = 1'b0;
    #1 m_reset();
    check_outputs("t6_async");
    @(posedge clk);
    #3 rst = 1'b1;
    press("t6_idle", 1); press("t6_idle", 2); idle("t6_idle");
    start("t6_restart", 16'h4321);

    // Random traffic biased toward the target so wins, losses and lockouts all occur.
    for (int c = 0; c < 2000; c++) begin
      int r;
      logic [3:0] d;
      bit dv, cl, rs;
      r  = $urandom_range(0, 99);
      rs = (r < 3);
      t  = '0;
      if (rs) for (int k = 0; k < ND; k++) t = (t << 4) | 16'($urandom_range(0, 9));
      dv = ($urandom_range(0, 1) == 1);
      cl = ($urandom_range(0, 29) == 0);
      r  = $urandom_range(0, 9);
      if (r < 6 && m_q.size() < ND)
        d = m_tgt[4*(ND-1-m_q.size()) +: 4];
      else if (r < 9)
        d = 4'($urandom_range(0, 9));
      else
        d = 4'($urandom_range(10, 15));
      cycle("rand", rs, t, dv, d, cl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
